// File: rtl/mdu_pkg.sv
// mdu_pkg
//   Shared definitions for the pipelined multiply/divide unit:
//   - mdu_op_t     : MDU opcode carried from ID/EXE (OP_NONE = 0 means "not an MDU op")
//   - mdu_state_t  : divide sequencer states
//   - MDU_DIV_CYCLES : iterations of the radix-2 divide core (one per operand bit)
//   - is_div_op()  : true for the two opcodes that start the iterative divider
package mdu_pkg;

  localparam int MDU_DIV_CYCLES = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MUL   = 4'd9
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/pipe_mdu_divider.sv
// pipe_mdu_divider
//   Unsigned radix-2 restoring divider, one quotient bit per clock.
//   Ports:
//     i_clk        rising-edge clock
//     i_reset      synchronous active-high reset (aborts any divide)
//     i_start      load operands and begin DIV_CYCLES iterations
//     i_dividend   unsigned dividend (sampled with i_start)
//     i_divisor    unsigned divisor  (sampled with i_start)
//     o_quotient   quotient after the step being performed this cycle
//     o_remainder  remainder after the step being performed this cycle
//     o_done       high in the cycle whose step is the last one; the
//                  quotient/remainder outputs are then final
//   A zero divisor needs no special case: every trial subtraction fits, so
//   the quotient comes out all ones and the remainder equals the dividend.
module pipe_mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // r_quot starts out holding the dividend; its MSB is shifted into the
  // partial remainder each step while the new quotient bit enters at the
  // bottom. The extra top bit of w_diff is the borrow of the trial subtract.
  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_divisor};
  assign w_fits      = ~w_diff[WIDTH];
  assign o_remainder = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quotient  = {r_quot[WIDTH-2:0], w_fits};
  assign o_done      = (r_count == CW'(1));

  // Operand load on start, then one restoring step per cycle until the
  // iteration counter reaches zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_count   <= CW'(DIV_CYCLES);
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
      r_rem   <= o_remainder;
      r_quot  <= o_quotient;
    end
  end

endmodule

// File: rtl/pipe_mdu.sv
// pipe_mdu
//   Multiply/divide unit of the EXE stage. Owns the HI/LO registers,
//   performs single-cycle multiplies and moves, and runs an iterative
//   divide in the background, requesting a pipeline stall only when another
//   MDU instruction arrives while the divide is still running.
//   Ports:
//     i_clk        rising-edge clock
//     i_reset      synchronous active-high reset
//     i_op_valid   EXE stage holds a valid instruction
//     i_op         MDU opcode (mdu_op_t encoding)
//     i_rs_value   operand A: dividend / multiplicand / MTHI-MTLO source
//     i_rt_value   operand B: divisor / multiplier
//     o_mdu_out    MFHI/MFLO/MUL result for rd, zero otherwise
//     o_stall      freeze request for the front of the pipeline
//     o_busy       divide in progress
//     o_hi, o_lo   current HI/LO contents
module pipe_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_op_valid,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_value,
  input  logic [WIDTH-1:0] i_rt_value,
  output logic [WIDTH-1:0] o_mdu_out,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  mdu_state_t r_state;
  mdu_state_t w_state_next;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_quot;
  logic             r_neg_rem;

  logic             w_is_mdu;
  logic             w_busy;
  logic             w_accept;
  logic             w_div_start;
  logic             w_signed_div;

  logic [2*WIDTH-1:0] w_rs_sx;
  logic [2*WIDTH-1:0] w_rt_sx;
  logic [2*WIDTH-1:0] w_rs_zx;
  logic [2*WIDTH-1:0] w_rt_zx;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;

  logic [WIDTH-1:0] w_dividend_mag;
  logic [WIDTH-1:0] w_divisor_mag;
  logic [WIDTH-1:0] w_quot_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_final;
  logic [WIDTH-1:0] w_rem_final;
  logic             w_div_done;

  // Handshake: an MDU op is taken only when no divide is running; while one
  // is, the op is held upstream and retried. Non-MDU traffic never stalls.
  assign w_is_mdu     = i_op_valid && (i_op != OP_NONE);
  assign w_busy       = (r_state == S_RUN);
  assign w_accept     = w_is_mdu && !w_busy;
  assign w_div_start  = w_accept && is_div_op(i_op);
  assign w_signed_div = (i_op == OP_DIV);

  assign o_stall = w_is_mdu && w_busy;
  assign o_busy  = w_busy;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  // Operands are widened explicitly so the 2*WIDTH-bit product is the exact
  // signed or unsigned result.
  assign w_rs_sx  = {{WIDTH{i_rs_value[WIDTH-1]}}, i_rs_value};
  assign w_rt_sx  = {{WIDTH{i_rt_value[WIDTH-1]}}, i_rt_value};
  assign w_rs_zx  = {{WIDTH{1'b0}}, i_rs_value};
  assign w_rt_zx  = {{WIDTH{1'b0}}, i_rt_value};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = w_rs_zx * w_rt_zx;

  // The core divides magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  assign w_dividend_mag = (w_signed_div && i_rs_value[WIDTH-1]) ? -i_rs_value : i_rs_value;
  assign w_divisor_mag  = (w_signed_div && i_rt_value[WIDTH-1]) ? -i_rt_value : i_rt_value;

  pipe_mdu_divider #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (w_div_start),
    .i_dividend  (w_dividend_mag),
    .i_divisor   (w_divisor_mag),
    .o_quotient  (w_quot_mag),
    .o_remainder (w_rem_mag),
    .o_done      (w_div_done)
  );

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend. This also yields the architected divide-by-zero results.
  assign w_quot_final = r_neg_quot ? -w_quot_mag : w_quot_mag;
  assign w_rem_final  = r_neg_rem  ? -w_rem_mag  : w_rem_mag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_next = S_RUN;
      S_RUN:   if (w_div_done)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sign fix-up flags are captured with the operands since rs/rt move on
  // while the divide runs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else if (w_div_start) begin
      r_neg_quot <= w_signed_div && (i_rs_value[WIDTH-1] ^ i_rt_value[WIDTH-1]);
      r_neg_rem  <= w_signed_div && i_rs_value[WIDTH-1];
    end
  end

  // HI/LO update: divide completion has its own write port; no op can be
  // accepted in the same cycle because the unit is still busy then.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_busy && w_div_done) begin
      r_hi <= w_rem_final;
      r_lo <= w_quot_final;
    end else if (w_accept) begin
      case (i_op)
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        OP_MTHI:  r_hi <= i_rs_value;
        OP_MTLO:  r_lo <= i_rs_value;
        default:  ;
      endcase
    end
  end

  // Result for rd is produced only for an accepted move-from or MUL.
  always_comb begin
    o_mdu_out = '0;
    if (w_accept) begin
      case (i_op)
        OP_MFHI: o_mdu_out = r_hi;
        OP_MFLO: o_mdu_out = r_lo;
        OP_MUL:  o_mdu_out = w_prod_s[WIDTH-1:0];
        default: o_mdu_out = '0;
      endcase
    end
  end

endmodule

// File: doc/pipe_mdu.md
# pipe_mdu

Iterative multiply/divide unit for the EXE stage of the five-stage pipeline. Sits between the ID/EXE register, which supplies operands and MDU opcode, and the EXE/MEM register, which captures `mdu_out` as `exe_MDU_out`. Owns the HI/LO architectural registers and raises `stall` while a multi-cycle divide blocks a dependent MDU instruction.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `DIV_CYCLES`, 32: iterations per divide; equals `WIDTH` for the radix-2 core.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; sampled only on `clk` rising edge.
- `op_valid`  in  1  EXE stage holds a valid MDU instruction.
- `op`  in  4  MDU opcode: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MUL.
- `rs_value`  in  WIDTH  operand A (dividend, multiplicand, MTHI/MTLO source).
- `rt_value`  in  WIDTH  operand B (divisor, multiplier).
- `mdu_out`  out  WIDTH  result for rd: HI (MFHI), LO (MFLO), low product (MUL); 0 otherwise.
- `stall`  out  1  freeze request; drives `we` low on IF/ID and ID/EXE; top level gates `exe_rf_we`/`exe_dmem_we` with `!stall` into EXE/MEM.
- `busy`  out  1  divide in progress.
- `hi`, `lo`  out  WIDTH  current HI/LO (debug/trace).

## Operation
- Accept when `op_valid && op != NONE && !busy`. `stall = op_valid && op != NONE && busy`; unaccepted op is held by the frozen ID/EXE register and retried each cycle.
- MULT/MULTU: 64-bit signed/unsigned product of `rs_value`×`rt_value` written {HI,LO} on the accepting edge.
- MUL: `mdu_out` = low 32 bits of signed product, combinational; HI/LO unchanged.
- MTHI/MTLO: HI/LO ← `rs_value` on accepting edge.
- MFHI/MFLO: `mdu_out` = HI/LO combinationally in the accepting cycle.
- DIV/DIVU: operands latched, FSM IDLE→RUN, counter loaded with `DIV_CYCLES`. DIV instruction itself retires without stall (writes no GPR).
- FSM RUN: one restoring-division step per cycle on magnitudes; counter decrements; on the edge where counter goes 1→0, HI ← remainder, LO ← quotient, FSM → IDLE.
- Signed fix-up (DIV): quotient negated if signs differ; remainder takes sign of dividend.
- Divide by zero: no trap; HI = `rs_value`; LO = 0xFFFFFFFF (DIVU, or DIV with rs ≥ 0), 0x00000001 (DIV with rs < 0). Still 32 cycles.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Non-MDU instructions (`op` = NONE) never stall, even while busy.

## Timing
- Reset (synchronous): HI = 0, LO = 0, FSM IDLE, counter 0, `busy` = 0, `stall` = 0; `mdu_out` = 0 while `op_valid` = 0. Reset mid-divide aborts; HI/LO cleared, no late write.
- MULT/MTHI/MTLO: HI/LO visible the cycle after accept; back-to-back MULT then MFLO has no stall.
- Divide accepted at edge E: `busy` high cycles E+1 … E+32; HI/LO written at edge E+32; `busy` low from E+32.
- MFHI/MFLO/MULT/DIV presented during busy: `stall` high until edge E+32, accepted in the following cycle with new HI/LO.
- `stall` and `busy` combinational from FSM state and `op_valid`/`op`; no cycle-delayed stall.

## Structure
- Package `mdu_pkg`: `mdu_op_t` encodings (NONE = 0), `DIV_CYCLES`, FSM state enum {IDLE, RUN}.
- Sub-module `pipe_mdu_divider`: unsigned radix-2 restoring core (start, dividend, divisor → quotient, remainder, done); sign handling and HI/LO in `pipe_mdu`.

## Test plan
- Reset then MFHI, MFLO → `mdu_out` 0, 0; `stall` 0.
- MULT 0xFFFFFFFF×2 → HI 0xFFFFFFFF, LO 0xFFFFFFFE; MULTU same operands → HI 0x00000001, LO 0xFFFFFFFE; MUL 7×(−3) → `mdu_out` 0xFFFFFFEB, HI/LO unchanged.
- DIV −7/2 then immediate MFLO → `stall` high 32 cycles, then LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 100/7 → LO 14, HI 2.
- DIV 0x80000000/−1 → LO 0x80000000, HI 0; DIVU 5/0 → LO 0xFFFFFFFF, HI 5; DIV −5/0 → LO 1, HI 0xFFFFFFFB.
- DIV accepted, non-MDU ops follow for 10 cycles → `stall` 0 throughout, `busy` 1; MTLO at cycle 12 → stalls until divide completes, then LO = MTLO value.
- `reset` asserted at cycle 15 of a divide → next cycle `busy` 0, HI/LO 0, no write at original completion edge.
